clock_time_counter: RTL and testbench
=====================================

# clock_time_counter

Timekeeping core of the clock design. Consumes the slow square wave produced by the 1 Hz clock divider and keeps hours, minutes and seconds in binary. Supports a user set mode with minute/hour increment buttons. All logic runs in the fast system clock domain: the slow wave is edge-detected, never used as a clock.

## Interface
Parameters:
- HOUR_MOD, 24, hour modulus (24 or 12); hour counts 0..HOUR_MOD-1.

Ports:
- clk_in  input  1  system clock (100 MHz); the only clock.
- rst  input  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- clk_slow  input  1  square wave from the divider, generated in the clk_in domain; each rising edge is one second.
- set_mode  input  1  level; 1 = set mode (counting frozen, seconds held at 0).
- inc_min  input  1  button level, already debounced; each rising edge adds one minute in set mode.
- inc_hour  input  1  button level, already debounced; each rising edge adds one hour in set mode.
- sec  output  6  seconds, 0..59.
- min  output  6  minutes, 0..59.
- hour  output  5  hours, 0..HOUR_MOD-1.
- sec_tick  output  1  one-cycle pulse, coincident with every seconds update in run mode.
- day_wrap  output  1  one-cycle pulse when hour rolls HOUR_MOD-1 -> 0 by carry.

## Operation
- Edge detection: registers slow_q <= clk_slow and slow_prev <= slow_q. Combinational slow_edge = slow_q & ~slow_prev. inc_min and inc_hour use identical detectors (min_edge, hour_edge).
- During rst, every sample register loads its live input (slow_q, slow_prev <= clk_slow; same for the buttons). An input already high at reset release produces no edge.
- Run mode (set_mode=0), on slow_edge:
  - sec increments. At 59 it wraps to 0 and carries to min.
  - min increments on carry. At 59 it wraps to 0 and carries to hour.
  - hour increments on carry. At HOUR_MOD-1 it wraps to 0 and day_wrap pulses.
  - sec_tick pulses.
- Run mode ignores button edges.
- Set mode (set_mode=1):
  - sec is forced to 0 every cycle.
  - slow_edge is ignored; sec_tick and day_wrap stay 0.
  - min_edge: min = (min+1) mod 60, with no carry into hour.
  - hour_edge: hour = (hour+1) mod HOUR_MOD, with no day_wrap.
  - Both edges in the same cycle: both fields update independently.
- Leaving set mode: counting resumes from sec=0 on the next slow_edge. An edge in the same cycle set_mode falls is counted.
- Holding a button high gives exactly one increment; there is no auto-repeat.
- Arithmetic: compare for wrap before adding; no field ever holds an out-of-range value.

## Timing
- Reset values: sec=0, min=0, hour=0, sec_tick=0, day_wrap=0. Reset asserted mid-operation clears all outputs at the next clk_in edge.
- Latency: clk_slow rising as sampled at clk_in edge k sets slow_q; sec/min/hour update and sec_tick is high after edge k+1. This is 2 clk_in edges from sampled input to new output.
- sec_tick and day_wrap are registered, high exactly one cycle, aligned with the new counter values.
- Button latency is identical: 2 edges from sampled rising level to the updated field.
- Full rollover (HOUR_MOD-1:59:59 -> 0:0:0) happens in a single cycle: all three fields change together and day_wrap=1 in that cycle.
- Minimum clk_slow high and low time: 1 clk_in cycle each. Edges faster than this are not guaranteed.

## Test plan
- Reset with clk_slow=1 held, then release -> outputs stay 0:0:0; no sec_tick until the next genuine rising edge.
- 60 clk_slow periods (e.g. 10 clk_in high / 10 low) -> sec_tick count 60, final min=1 sec=0. Each update occurs 2 clk_in edges after the sampled rising edge.
- Set mode: 59 inc_min pulses plus 23 inc_hour pulses, exit, then 60 slow edges -> passes through 23:59:59 to 0:0:0 with day_wrap=1 for one cycle and sec_tick=1 in the same cycle.
- Set mode: inc_min held high for 100 cycles at min=59 -> min=0 exactly once, hour unchanged. Simultaneous inc_min and inc_hour edges -> both fields +1.
- Set mode entered at sec=37 -> sec=0 next cycle. Slow edges during set mode -> no change, no sec_tick.
- rst asserted for 1 cycle at 5:30:12 mid-count -> 0:0:0 after that edge. HOUR_MOD=12 run: 11:59:59 + one tick -> 0:0:0, day_wrap=1.

Source files
------------

// File: rtl/clock_time_counter.sv
// clock_time_counter: binary hh:mm:ss timekeeping driven by an edge-detected 1 Hz wave, with set-mode buttons
module clock_time_counter #(
    parameter int HOUR_MOD = 24
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       clk_slow,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       sec_tick,
    output logic       day_wrap
);
    localparam logic [4:0] HOUR_MAX = 5'(HOUR_MOD - 1);
    logic       slow_q, slow_prev, min_q, min_prev, hour_q, hour_prev;
    logic       slow_edge, min_edge, hour_edge;
    logic       run_step, sec_wrap, min_wrap, hour_wrap, min_inc, hour_inc;
    logic [5:0] sec_nx, min_nx;
    logic [4:0] hour_nx;
    assign slow_edge = slow_q & ~slow_prev;
    assign min_edge  = min_q & ~min_prev;
    assign hour_edge = hour_q & ~hour_prev;
    always_comb begin
        run_step  = ~set_mode & slow_edge;
        sec_wrap  = sec == 6'd59;
        min_wrap  = min == 6'd59;
        hour_wrap = hour == HOUR_MAX;
        min_inc   = set_mode ? min_edge : run_step & sec_wrap;
        hour_inc  = set_mode ? hour_edge : run_step & sec_wrap & min_wrap;
        sec_nx    = set_mode ? 6'd0 : run_step ? (sec_wrap ? 6'd0 : sec + 6'd1) : sec;
        min_nx    = min_inc ? (min_wrap ? 6'd0 : min + 6'd1) : min;
        hour_nx   = hour_inc ? (hour_wrap ? 5'd0 : hour + 5'd1) : hour;
    end
    // Samplers load the live level during reset so an input already high yields no edge
    always_ff @(posedge clk_in) begin
        if (rst) begin
            slow_q    <= clk_slow;
            slow_prev <= clk_slow;
            min_q     <= inc_min;
            min_prev  <= inc_min;
            hour_q    <= inc_hour;
            hour_prev <= inc_hour;
            sec       <= '0;
            min       <= '0;
            hour      <= '0;
            sec_tick  <= 1'b0;
            day_wrap  <= 1'b0;
        end else begin
            slow_q    <= clk_slow;
            slow_prev <= slow_q;
            min_q     <= inc_min;
            min_prev  <= min_q;
            hour_q    <= inc_hour;
            hour_prev <= hour_q;
            sec       <= sec_nx;
            min       <= min_nx;
            hour      <= hour_nx;
            sec_tick  <= run_step;
            day_wrap  <= run_step & sec_wrap & min_wrap & hour_wrap;
        end
    end
    a_range: assert property (@(posedge clk_in) disable iff (rst)
        sec < 6'd60 && min < 6'd60 && hour <= HOUR_MAX);
endmodule

// File: tb/tb_clock_time_counter.sv
// tb_clock_time_counter: table vectors, directed corner sequences and random stimulus against a time-of-day model
module tb_clock_time_counter;
    logic clk_in = 1'b0;
    logic rst, slow, sm, im, ih;
    logic [5:0] s24, m24, s12, m12;
    logic [4:0] h24, h12;
    logic t24, w24, t12, w12;
    int checks = 0, failures = 0, ncyc = 0;
    int tick_cnt, wrap24_cnt, wrap12_cnt, coinc;
    int es[2], em[2], eh[2], et[2], ew[2];
    int hmv[2] = '{24, 12};
    bit p_s1, p_s2, p_m1, p_m2, p_h1, p_h2;

    typedef struct {
        logic r, s, sm, im, ih;
        int   es, em, eh, et, ew;
    } vec_t;
    vec_t tbl[16];

    always #5 clk_in = ~clk_in;

    clock_time_counter #(.HOUR_MOD(24)) dut24 (
        .clk_in(clk_in), .rst(rst), .clk_slow(slow), .set_mode(sm), .inc_min(im), .inc_hour(ih),
        .sec(s24), .min(m24), .hour(h24), .sec_tick(t24), .day_wrap(w24));
    clock_time_counter #(.HOUR_MOD(12)) dut12 (
        .clk_in(clk_in), .rst(rst), .clk_slow(slow), .set_mode(sm), .inc_min(im), .inc_hour(ih),
        .sec(s12), .min(m12), .hour(h12), .sec_tick(t12), .day_wrap(w12));

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: rising edges are seen one sample late; run mode advances a seconds-of-day count
    task automatic model_step();
        bit se, me, he;
        int t;
        se = p_s1 && !p_s2;
        me = p_m1 && !p_m2;
        he = p_h1 && !p_h2;
        for (int i = 0; i < 2; i++) begin
            et[i] = 0;
            ew[i] = 0;
            if (rst) begin
                es[i] = 0; em[i] = 0; eh[i] = 0;
            end else if (sm) begin
                es[i] = 0;
                if (me) em[i] = (em[i] + 1) % 60;
                if (he) eh[i] = (eh[i] + 1) % hmv[i];
            end else if (se) begin
                t = eh[i] * 3600 + em[i] * 60 + es[i] + 1;
                if (t == hmv[i] * 3600) begin
                    t = 0;
                    ew[i] = 1;
                end
                et[i] = 1;
                eh[i] = t / 3600;
                em[i] = (t / 60) % 60;
                es[i] = t % 60;
            end
        end
        p_s2 = rst ? slow : p_s1; p_s1 = slow;
        p_m2 = rst ? im : p_m1;   p_m1 = im;
        p_h2 = rst ? ih : p_h1;   p_h1 = ih;
    endtask

    task automatic cmp_model(int i, int s, int m, int h, int t, int w);
        checks++;
        if (s != es[i] || m != em[i] || h != eh[i] || t != et[i] || w != ew[i]) begin
            failures++;
            $display("FAIL model_mod%0d cyc %0d: got %0d:%0d:%0d tick=%0d wrap=%0d want %0d:%0d:%0d tick=%0d wrap=%0d",
                     hmv[i], ncyc, h, m, s, t, w, eh[i], em[i], es[i], et[i], ew[i]);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        ncyc++;
        model_step();
        #1;
        cmp_model(0, s24, m24, h24, t24, w24);
        cmp_model(1, s12, m12, h12, t12, w12);
        tick_cnt += int'(t24);
        wrap24_cnt += int'(w24);
        wrap12_cnt += int'(w12);
        if (w24 && t24) coinc++;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic do_reset();
        rst = 1; cyc(); rst = 0;
    endtask

    task automatic pulse_min(int n);
        for (int k = 0; k < n; k++) begin im = 1; cyc(); im = 0; cyc(); end
    endtask

    task automatic pulse_hour(int n);
        for (int k = 0; k < n; k++) begin ih = 1; cyc(); ih = 0; cyc(); end
    endtask

    task automatic periods(int n, int hi, int lo);
        for (int k = 0; k < n; k++) begin slow = 1; idle(hi); slow = 0; idle(lo); end
    endtask

    task automatic chk_time(string name, int h, int m, int s);
        chk({name, "_hour"}, h24, h);
        chk({name, "_min"}, m24, m);
        chk({name, "_sec"}, s24, s);
    endtask

    initial begin
        int hsave, zero_cnt;
        logic [5:0] mprev;
        tick_cnt = 0; wrap24_cnt = 0; wrap12_cnt = 0; coinc = 0;
        //           r  s sm im ih  sec min hr tk wr
        tbl[0]  = '{1, 1, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 0,  1, 0, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 1, 0,  0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 1, 1, 1,  0, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 1, 1,  0, 1, 1, 0, 0};
        tbl[10] = '{0, 0, 1, 0, 0,  0, 1, 1, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 0,  0, 1, 1, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 0,  1, 1, 1, 1, 0};
        tbl[13] = '{0, 0, 0, 0, 0,  1, 1, 1, 0, 0};
        tbl[14] = '{0, 0, 1, 1, 1,  0, 1, 1, 0, 0};
        tbl[15] = '{0, 0, 1, 0, 0,  0, 2, 2, 0, 0};
        for (int v = 0; v < 16; v++) begin
            rst = tbl[v].r; slow = tbl[v].s; sm = tbl[v].sm; im = tbl[v].im; ih = tbl[v].ih;
            cyc();
            chk($sformatf("vec%0d_sec", v), s24, tbl[v].es);
            chk($sformatf("vec%0d_min", v), m24, tbl[v].em);
            chk($sformatf("vec%0d_hour", v), h24, tbl[v].eh);
            chk($sformatf("vec%0d_tick", v), t24, tbl[v].et);
            chk($sformatf("vec%0d_wrap", v), w24, tbl[v].ew);
        end
        // 60 slow periods from reset, first one checked for latency
        sm = 0; im = 0; ih = 0; slow = 0;
        do_reset();
        tick_cnt = 0;
        slow = 1; cyc();
        chk("lat_edge_k_tick", t24, 0);
        cyc();
        chk("lat_edge_k1_tick", t24, 1);
        chk("lat_edge_k1_sec", s24, 1);
        idle(8); slow = 0; idle(10);
        periods(59, 10, 10);
        chk("sixty_ticks", tick_cnt, 60);
        chk_time("sixty", 0, 1, 0);
        // Set to 23:59 (11:59 on the 12-hour core), then run through the day boundary
        do_reset();
        sm = 1; pulse_min(59); pulse_hour(23);
        chk_time("set_2359", 23, 59, 0);
        chk("set_hour12", h12, 11);
        sm = 0; cyc();
        wrap24_cnt = 0; wrap12_cnt = 0; coinc = 0;
        periods(60, 2, 2);
        chk("day_wrap24_cnt", wrap24_cnt, 1);
        chk("day_wrap12_cnt", wrap12_cnt, 1);
        chk("wrap_with_tick", coinc, 1);
        chk_time("rollover", 0, 0, 0);
        chk("rollover12_hour", h12, 0);
        // Held button at min=59, then simultaneous buttons
        sm = 1; pulse_min(59);
        hsave = h24; zero_cnt = 0; im = 1;
        for (int k = 0; k < 100; k++) begin
            mprev = m24; cyc();
            if (mprev == 6'd59 && m24 == 6'd0) zero_cnt++;
        end
        im = 0; cyc();
        chk("held_wraps", zero_cnt, 1);
        chk("held_min", m24, 0);
        chk("held_hour", h24, hsave);
        im = 1; ih = 1; cyc(); im = 0; ih = 0; cyc();
        chk("both_min", m24, 1);
        chk("both_hour", h24, hsave + 1);
        // Enter set mode at sec=37; slow edges must be ignored there
        sm = 0; do_reset();
        periods(37, 2, 2);
        chk("pre_set_sec", s24, 37);
        sm = 1; cyc();
        chk("set_clears_sec", s24, 0);
        tick_cnt = 0;
        periods(5, 2, 2);
        chk("set_no_ticks", tick_cnt, 0);
        chk_time("set_frozen", 0, 0, 0);
        // Mid-count reset at 5:30:12
        do_reset();
        sm = 1; pulse_hour(5); pulse_min(30); sm = 0; cyc();
        periods(12, 2, 2);
        chk_time("pre_rst", 5, 30, 12);
        do_reset();
        chk_time("post_rst", 0, 0, 0);
        chk("post_rst_tick", t24, 0);
        // Random stimulus against the model
        for (int k = 0; k < 4000; k++) begin
            rst  = ($urandom_range(0, 299) == 0);
            slow = ($urandom_range(0, 3) == 0) ? ~slow : slow;
            if ($urandom_range(0, 49) == 0) sm = ~sm;
            im = ($urandom_range(0, 2) == 0) ? ~im : im;
            ih = ($urandom_range(0, 4) == 0) ? ~ih : ih;
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
